// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 8x16 register file fed through a 2-entry in-order write
// queue, with operand forwarding from queued entries and registered status flags.
module alu_wb_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [15:0] Y,
   input  logic        N,
   input  logic        Z,
   input  logic        C,
   input  logic        W_En,
   input  logic [2:0]  W_Adr,
   input  logic        Flag_Ld,
   input  logic        Wb_Stall,
   input  logic [2:0]  R_Adr,
   input  logic [2:0]  S_Adr,
   output logic [15:0] Reg_R,
   output logic [15:0] Reg_S,
   output logic        N_Flag,
   output logic        Z_Flag,
   output logic        C_Flag,
   output logic [1:0]  Pending
);

   logic [15:0] r_regs [0:7];
   logic [2:0]  r_q0_adr;
   logic [15:0] r_q0_data;
   logic [2:0]  r_q1_adr;
   logic [15:0] r_q1_data;
   logic [1:0]  r_pending;
   logic        r_n_flag;
   logic        r_z_flag;
   logic        r_c_flag;

   logic        w_accept;
   logic        w_enq;
   logic        w_drain;
   logic [1:0]  w_base;
   logic [1:0]  w_pending_nxt;
   logic [2:0]  w_sh0_adr;
   logic [15:0] w_sh0_data;
   logic [2:0]  w_q0_adr_nxt;
   logic [15:0] w_q0_data_nxt;
   logic [2:0]  w_q1_adr_nxt;
   logic [15:0] w_q1_data_nxt;

   assign In_Ready = (r_pending < 2'd2) && !reset;
   assign w_accept = In_Valid && In_Ready;
   assign w_enq    = w_accept && W_En;
   assign w_drain  = (r_pending != 2'd0) && !Wb_Stall;

   // Occupancy after the head pops; the new entry lands in that slot.
   assign w_base        = w_drain ? (r_pending - 2'd1) : r_pending;
   assign w_pending_nxt = w_base + {1'b0, w_enq};

   assign w_sh0_adr     = w_drain ? r_q1_adr  : r_q0_adr;
   assign w_sh0_data    = w_drain ? r_q1_data : r_q0_data;
   assign w_q0_adr_nxt  = (w_enq && (w_base == 2'd0)) ? W_Adr : w_sh0_adr;
   assign w_q0_data_nxt = (w_enq && (w_base == 2'd0)) ? Y     : w_sh0_data;
   assign w_q1_adr_nxt  = (w_enq && (w_base == 2'd1)) ? W_Adr : r_q1_adr;
   assign w_q1_data_nxt = (w_enq && (w_base == 2'd1)) ? Y     : r_q1_data;

   // Youngest matching queued entry wins over the register file.
   assign Reg_R = ((r_pending == 2'd2) && (r_q1_adr == R_Adr)) ? r_q1_data :
                  ((r_pending != 2'd0) && (r_q0_adr == R_Adr)) ? r_q0_data :
                  r_regs[R_Adr];
   assign Reg_S = ((r_pending == 2'd2) && (r_q1_adr == S_Adr)) ? r_q1_data :
                  ((r_pending != 2'd0) && (r_q0_adr == S_Adr)) ? r_q0_data :
                  r_regs[S_Adr];

   assign Pending = r_pending;
   assign N_Flag  = r_n_flag;
   assign Z_Flag  = r_z_flag;
   assign C_Flag  = r_c_flag;

   // Register file, write queue and flag state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= 16'h0000;
         end
         r_q0_adr  <= 3'd0;
         r_q0_data <= 16'h0000;
         r_q1_adr  <= 3'd0;
         r_q1_data <= 16'h0000;
         r_pending <= 2'd0;
         r_n_flag  <= 1'b0;
         r_z_flag  <= 1'b0;
         r_c_flag  <= 1'b0;
      end else begin
         if (w_drain) begin
            r_regs[r_q0_adr] <= r_q0_data;
         end
         r_q0_adr  <= w_q0_adr_nxt;
         r_q0_data <= w_q0_data_nxt;
         r_q1_adr  <= w_q1_adr_nxt;
         r_q1_data <= w_q1_data_nxt;
         r_pending <= w_pending_nxt;
         if (w_accept && Flag_Ld) begin
            r_n_flag <= N;
            r_z_flag <= Z;
            r_c_flag <= C;
         end
      end
   end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage: a queue-based reference model predicts the
// per-cycle outputs; a separate monitor pops and compares them.
module tb_alu_wb_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [15:0] Y = 16'h0000;
   logic        N = 1'b0, Z = 1'b0, C = 1'b0;
   logic        W_En = 1'b0;
   logic [2:0]  W_Adr = 3'd0;
   logic        Flag_Ld = 1'b0;
   logic        Wb_Stall = 1'b0;
   logic [2:0]  R_Adr = 3'd0, S_Adr = 3'd0;
   logic [15:0] Reg_R, Reg_S;
   logic        N_Flag, Z_Flag, C_Flag;
   logic [1:0]  Pending;

   alu_wb_stage dut (
      .clk(clk), .reset(reset), .In_Valid(In_Valid), .In_Ready(In_Ready),
      .Y(Y), .N(N), .Z(Z), .C(C), .W_En(W_En), .W_Adr(W_Adr),
      .Flag_Ld(Flag_Ld), .Wb_Stall(Wb_Stall), .R_Adr(R_Adr), .S_Adr(S_Adr),
      .Reg_R(Reg_R), .Reg_S(Reg_S), .N_Flag(N_Flag), .Z_Flag(Z_Flag),
      .C_Flag(C_Flag), .Pending(Pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, vld;
      logic [15:0] y;
      logic        wen;
      logic [2:0]  wadr;
      logic        fld, n, z, c, stall;
      logic [2:0]  radr, sadr;
   } stim_t;

   typedef struct {
      logic        rdy;
      logic [1:0]  pend;
      logic [2:0]  flg;
      logic [15:0] r, s;
   } exp_t;

   typedef struct {
      logic [2:0]  adr;
      logic [15:0] data;
   } ent_t;

   ent_t        m_q[$];
   logic [15:0] m_reg [8];
   logic [2:0]  m_flags;
   exp_t        sb[$];
   int          n_pass = 0;
   int          n_total = 0;

   function automatic stim_t mk(input logic rst, input logic vld, input logic [15:0] y,
                                input logic wen, input logic [2:0] wadr, input logic fld,
                                input logic n, input logic z, input logic c,
                                input logic stall, input logic [2:0] radr,
                                input logic [2:0] sadr);
      stim_t s;
      s.rst = rst; s.vld = vld; s.y = y; s.wen = wen; s.wadr = wadr; s.fld = fld;
      s.n = n; s.z = z; s.c = c; s.stall = stall; s.radr = radr; s.sadr = sadr;
      return s;
   endfunction

   function automatic stim_t idle(input logic stall, input logic [2:0] radr,
                                  input logic [2:0] sadr);
      return mk(1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, stall, radr, sadr);
   endfunction

   // A read sees the youngest pending write to that address, else the register.
   function automatic logic [15:0] m_read(input logic [2:0] a);
      logic [15:0] v;
      v = m_reg[a];
      foreach (m_q[i]) begin
         if (m_q[i].adr == a) v = m_q[i].data;
      end
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   // Apply one cycle of stimulus, predict this cycle's outputs, then advance the model.
   task automatic step(input stim_t s, output logic acc);
      exp_t e;
      ent_t en;
      logic rdy;
      @(negedge clk);
      reset = s.rst; In_Valid = s.vld; Y = s.y; W_En = s.wen; W_Adr = s.wadr;
      Flag_Ld = s.fld; N = s.n; Z = s.z; C = s.c; Wb_Stall = s.stall;
      R_Adr = s.radr; S_Adr = s.sadr;
      rdy = !s.rst && (m_q.size() < 2);
      e.rdy = rdy;
      e.pend = 2'(m_q.size());
      e.flg = m_flags;
      e.r = m_read(s.radr);
      e.s = m_read(s.sadr);
      sb.push_back(e);
      acc = s.vld && rdy;
      if (s.rst) begin
         m_q.delete();
         for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
         m_flags = 3'b000;
      end else begin
         if (m_q.size() > 0 && !s.stall) begin
            en = m_q.pop_front();
            m_reg[en.adr] = en.data;
         end
         if (acc && s.wen) begin
            en.adr = s.wadr;
            en.data = s.y;
            m_q.push_back(en);
         end
         if (acc && s.fld) m_flags = {s.n, s.z, s.c};
      end
   endtask

   // Monitor: compare every predicted cycle against the DUT, mid-low-phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("in_ready", {15'd0, In_Ready}, {15'd0, e.rdy});
            chk("pending", {14'd0, Pending}, {14'd0, e.pend});
            chk("flags_nzc", {13'd0, N_Flag, Z_Flag, C_Flag}, {13'd0, e.flg});
            chk("reg_r", Reg_R, e.r);
            chk("reg_s", Reg_S, e.s);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic  acc;
      stim_t s;
      bit    held;
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_flags = 3'b000;

      // Reset, then every address reads zero right after release.
      step(mk(1'b1, 1'b1, 16'hDEAD, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2), acc);
      for (int a = 0; a < 8; a++) step(idle(1'b0, 3'(a), 3'(7 - a)), acc);

      // Basic write with flag load, forwarded next cycle.
      step(mk(1'b0, 1'b1, 16'hAA55, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd0), acc);
      step(idle(1'b0, 3'd3, 3'd3), acc);
      step(idle(1'b0, 3'd3, 3'd1), acc);

      // Two writes to r2 under stall, then drain.
      step(mk(1'b0, 1'b1, 16'h1111, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2), acc);
      step(mk(1'b0, 1'b1, 16'h2222, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd2), acc);
      step(mk(1'b0, 1'b1, 16'h3333, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2), acc);
      for (int k = 0; k < 3; k++) step(idle(1'b0, 3'd2, 3'd2), acc);

      // Full queue, third transaction held until space opens.
      step(mk(1'b0, 1'b1, 16'h4444, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd5), acc);
      step(mk(1'b0, 1'b1, 16'h5555, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd5), acc);
      acc = 1'b0;
      for (int k = 0; k < 4 && !acc; k++)
         step(mk(1'b0, 1'b1, 16'h6666, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 3'd5), acc);
      for (int k = 0; k < 3; k++) step(idle(1'b0, 3'd6, 3'd4), acc);

      // Flag-only transaction.
      step(mk(1'b0, 1'b1, 16'hFFFF, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7), acc);
      step(idle(1'b0, 3'd0, 3'd7), acc);

      // Queue two entries, then reset discards them.
      step(mk(1'b0, 1'b1, 16'h7777, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd7), acc);
      step(mk(1'b0, 1'b1, 16'h8888, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd7), acc);
      step(mk(1'b1, 1'b1, 16'h9999, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd7), acc);
      for (int k = 0; k < 3; k++) step(idle(1'b0, 3'd1, 3'd7), acc);

      // Back-to-back accepts r0..r7, forwarding checked each cycle.
      for (int a = 0; a < 8; a++)
         step(mk(1'b0, 1'b1, 16'(16'h0101 * (a + 1)), 1'b1, 3'(a), 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 3'(a == 0 ? 0 : a - 1), 3'(a)), acc);
      for (int a = 0; a < 8; a++) step(idle(1'b0, 3'(a), 3'(7 - a)), acc);

      // Randomized traffic; a refused transaction is held by the sender.
      held = 1'b0;
      s = idle(1'b0, 3'd0, 3'd0);
      for (int k = 0; k < 400; k++) begin
         if (!held) begin
            s.vld  = ($urandom_range(0, 3) != 0);
            s.y    = 16'($urandom);
            s.wen  = ($urandom_range(0, 3) != 0);
            s.wadr = 3'($urandom_range(0, 7));
            s.fld  = ($urandom_range(0, 1) != 0);
            s.n    = ($urandom_range(0, 1) != 0);
            s.z    = ($urandom_range(0, 1) != 0);
            s.c    = ($urandom_range(0, 1) != 0);
         end
         s.rst   = ($urandom_range(0, 80) == 0);
         s.stall = ($urandom_range(0, 2) == 0);
         s.radr  = 3'($urandom_range(0, 7));
         s.sadr  = 3'($urandom_range(0, 7));
         step(s, acc);
         held = s.vld && !acc && !s.rst;
      end
      for (int k = 0; k < 4; k++) step(idle(1'b0, 3'(k), 3'(k + 4)), acc);

      @(negedge clk);
      #5;
      chk("scoreboard_drained", 16'(sb.size()), 16'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
